// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: word length, lane count, writeback FSM states and
// the lane slice helper used by both the memory read side and the writeback
// packer, so lane k always sits at bits [k*WL +: WL] on either side.
package lstm_pkg;

    localparam int WL_DEF    = 12;
    localparam int N_LANES   = 16;
    localparam int STEPS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } lstm_state_t;

    // LSB position of lane k in a packed vector of wl-bit words.
    function automatic int lane_lsb(input int k, input int wl);
        return k * wl;
    endfunction

endpackage

// File: rtl/lstm_lane_packer.sv
// Purpose: collects serial h/c elements into N-lane packed vectors.
// Latency: element written at the accepting edge; pack_full rises on the edge accepting lane N-1.
// Backpressure: caller must not write while pack_full; take empties the pack.
// Ports: clk/rst (async active-low), clear (restart at lane 0), wr (accept element),
//        take (pack copied out), h_in/c_in (element), h_pack/c_pack (lanes), pack_full.
module lstm_lane_packer
    import lstm_pkg::*;
#(
    parameter int WL = WL_DEF,
    parameter int N  = N_LANES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            wr,
    input  logic            take,
    input  logic [WL-1:0]   h_in,
    input  logic [WL-1:0]   c_in,
    output logic [N*WL-1:0] h_pack,
    output logic [N*WL-1:0] c_pack,
    output logic            pack_full
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane      <= '0;
            pack_full <= 1'b0;
            h_pack    <= '0;
            c_pack    <= '0;
        end else if (clear) begin
            // Pack contents are left alone: every lane is rewritten before
            // the next transfer, so stale data can never escape.
            lane      <= '0;
            pack_full <= 1'b0;
        end else begin
            if (wr) begin
                // Indexed write, no shifting: each lane register only
                // loads when the counter points at it.
                for (int k = 0; k < N; k++) begin
                    if (lane == CW'(k)) begin
                        h_pack[lane_lsb(k, WL) +: WL] <= h_in;
                        c_pack[lane_lsb(k, WL) +: WL] <= c_in;
                    end
                end
                if (lane == CW'(N - 1)) begin
                    lane      <= '0;
                    pack_full <= 1'b1;
                end else begin
                    lane <= lane + 1'b1;
                end
            end
            if (take) begin
                pack_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lstm_hc_writeback.sv
// Purpose: packs serial h_new/c_new elements into 16-lane vectors and hands them to memory, STEPS per run.
// Latency: last element of a step accepted in cycle t -> out_valid in cycle t+2 (one bubble).
// Backpressure: in_ready drops while a full pack waits for the output register; output holds until out_ack.
// Ports: clk, rst (async active-low), start, in_valid/in_ready/h_in/c_in (element stream),
//        out_valid/out_ack/h_vec/c_vec (vector handshake), step_idx, busy, done.
module lstm_hc_writeback
    import lstm_pkg::*;
#(
    parameter int WL    = WL_DEF,
    parameter int N     = N_LANES,
    parameter int STEPS = STEPS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WL-1:0]              h_in,
    input  logic [WL-1:0]              c_in,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic [N*WL-1:0]            h_vec,
    output logic [N*WL-1:0]            c_vec,
    output logic [$clog2(STEPS+1)-1:0] step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int SW = $clog2(STEPS + 1);

    lstm_state_t     state;
    logic            pack_full;
    logic [N*WL-1:0] h_pack;
    logic [N*WL-1:0] c_pack;
    logic            accept;
    logic            transfer;
    logic            clear;

    assign in_ready = (state == ST_RUN) && !pack_full;
    assign accept   = in_valid && in_ready;
    // The output register is free if empty or being acknowledged this cycle;
    // the ack then retires the old vector while the new one loads.
    assign transfer = (state == ST_RUN) && pack_full && (!out_valid || out_ack);
    assign clear    = (state == ST_IDLE) && start;
    assign busy     = (state != ST_IDLE);

    lstm_lane_packer #(
        .WL (WL),
        .N  (N)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr        (accept),
        .take      (transfer),
        .h_in      (h_in),
        .c_in      (c_in),
        .h_pack    (h_pack),
        .c_pack    (c_pack),
        .pack_full (pack_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            h_vec     <= '0;
            c_vec     <= '0;
            step_idx  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        step_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (transfer) begin
                        h_vec     <= h_pack;
                        c_vec     <= c_pack;
                        out_valid <= 1'b1;
                        step_idx  <= step_idx + 1'b1;
                        if (step_idx == SW'(STEPS - 1)) begin
                            state <= ST_DRAIN;
                        end
                    end else if (out_valid && out_ack) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Last vector is already in the output register; wait
                    // for memory to take it before signalling completion.
                    if (out_valid && out_ack) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_hc_writeback.sv
module tb_lstm_hc_writeback;

    localparam int WL    = 12;
    localparam int N     = 16;
    localparam int STEPS = 8;
    localparam int SW    = $clog2(STEPS + 1);

    typedef logic [N*WL-1:0] vec_t;
    typedef struct packed {
        vec_t h;
        vec_t c;
    } pair_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] h_in;
    logic [WL-1:0] c_in;
    logic          out_valid;
    logic          out_ack;
    vec_t          h_vec;
    vec_t          c_vec;
    logic [SW-1:0] step_idx;
    logic          busy;
    logic          done;

    int    errors = 0;
    int    checks = 0;
    pair_t exp_q[$];
    vec_t  fin_h;
    vec_t  fin_c;

    lstm_hc_writeback #(.WL(WL), .N(N), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .h_vec     (h_vec),
        .c_vec     (c_vec),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
        $fatal(1);
    end

    function automatic logic [WL-1:0] hval(input int s, input int k);
        return WL'((s * 16 + k) * 7 + 3);
    endfunction

    function automatic logic [WL-1:0] cval(input int s, input int k);
        return 12'hFFF ^ WL'((s * 16 + k) * 13);
    endfunction

    function automatic vec_t mk_h(input int s);
        vec_t v;
        for (int k = 0; k < N; k++) v[k*WL +: WL] = hval(s, k);
        return v;
    endfunction

    function automatic vec_t mk_c(input int s);
        vec_t v;
        for (int k = 0; k < N; k++) v[k*WL +: WL] = cval(s, k);
        return v;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        out_ack  = 1'b0;
        h_in     = '0;
        c_in     = '0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one element until accepted; with junk set, garbage is driven
    // while in_ready is low to prove such cycles are ignored.
    task automatic send(input logic [WL-1:0] h, input logic [WL-1:0] c, input bit junk);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            in_valid = 1'b1;
            if (in_ready) begin
                h_in = h;
                c_in = c;
                acc  = 1'b1;
            end else begin
                h_in = junk ? WL'($urandom) : h;
                c_in = junk ? WL'($urandom) : c;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready never high, got=0 want=1");
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (h_vec !== '0 || c_vec !== '0) begin errors++; $display("FAIL reset_vectors got=%h/%h want=0", h_vec, c_vec); end
        checks++; if (step_idx !== '0) begin errors++; $display("FAIL reset_step_idx got=%0d want=0", step_idx); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got=rdy%0b busy%0b done%0b want=000", in_ready, busy, done); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            h_in = WL'(i + 1);
            c_in = WL'(i + 9);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || step_idx !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_ignore got=rdy%0b idx%0d ov%0b busy%0b want=0/0/0/0", in_ready, step_idx, out_valid, busy); end
    endtask

    task automatic test_single_step();
        vec_t eh, ec;
        do_reset();
        out_ack = 1'b1;
        pulse_start();
        for (int k = 0; k < N; k++) begin
            eh[k*WL +: WL] = WL'(k);
            ec[k*WL +: WL] = WL'(12'h100 + k);
            send(WL'(k), WL'(12'h100 + k), 1'b0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_bubble out_valid got=%0b want=0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency out_valid got=%0b want=1", out_valid); end
        checks++; if (h_vec !== eh) begin errors++; $display("FAIL single_h got=%h want=%h", h_vec, eh); end
        checks++; if (c_vec !== ec) begin errors++; $display("FAIL single_c got=%h want=%h", c_vec, ec); end
        checks++; if (step_idx !== SW'(1)) begin errors++; $display("FAIL single_step_idx got=%0d want=1", step_idx); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_acked out_valid got=%0b want=0", out_valid); end
        out_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ack = 1'b0;
        pulse_start();
        for (int k = 0; k < N; k++) send(hval(0, k), cval(0, k), 1'b0);
        for (int k = 0; k < N; k++) send(hval(1, k), cval(1, k), 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b want=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || h_vec !== mk_h(0)) begin errors++; $display("FAIL bp_hold ov=%0b h=%h want ov=1 h=%h", out_valid, h_vec, mk_h(0)); end
        repeat (3) @(negedge clk);
        checks++; if (h_vec !== mk_h(0) || c_vec !== mk_c(0) || step_idx !== SW'(1)) begin errors++; $display("FAIL bp_stable h=%h idx=%0d want h=%h idx=1", h_vec, step_idx, mk_h(0)); end
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_ack_swap out_valid got=%0b want=1", out_valid); end
        checks++; if (h_vec !== mk_h(1) || c_vec !== mk_c(1)) begin errors++; $display("FAIL bp_new_data got=%h want=%h", h_vec, mk_h(1)); end
        checks++; if (in_ready !== 1'b1 || step_idx !== SW'(2)) begin errors++; $display("FAIL bp_resume rdy=%0b idx=%0d want rdy=1 idx=2", in_ready, step_idx); end
    endtask

    task automatic test_full_run(input bit inject);
        int    got, dones, n;
        pair_t e;
        do_reset();
        exp_q.delete();
        got   = 0;
        dones = 0;
        pulse_start();
        fork
            begin
                for (int s = 0; s < STEPS; s++) begin
                    exp_q.push_back('{h: mk_h(s), c: mk_c(s)});
                    for (int k = 0; k < N; k++) begin
                        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                        send(hval(s, k), cval(s, k), inject);
                    end
                end
            end
            begin
                n = 0;
                while (got < STEPS && n < 3000) begin
                    @(negedge clk);
                    n++;
                    if (done) dones++;
                    out_ack = ($urandom_range(0, 1) == 1);
                    if (out_valid && out_ack) begin
                        if (exp_q.size() == 0) begin
                            errors++;
                            checks++;
                            $display("FAIL run_extra_vector got=%h want=none", h_vec);
                        end else begin
                            e = exp_q.pop_front();
                            checks++; if (h_vec !== e.h || c_vec !== e.c) begin errors++; $display("FAIL run_vector%0d got=%h/%h want=%h/%h", got, h_vec, c_vec, e.h, e.c); end
                        end
                        if (got == STEPS - 1) begin
                            checks++; if (step_idx !== SW'(STEPS) || busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL run_drain idx=%0d busy=%0b rdy=%0b want 8/1/0", step_idx, busy, in_ready); end
                        end
                        got++;
                    end
                end
                repeat (4) begin
                    @(negedge clk);
                    if (done) dones++;
                    out_ack = ($urandom_range(0, 1) == 1);
                end
                out_ack = 1'b0;
            end
            begin
                if (inject) begin
                    repeat (30) begin
                        @(negedge clk);
                        start = (busy && step_idx < SW'(STEPS)) ? ($urandom_range(0, 3) == 0) : 1'b0;
                    end
                    start = 1'b0;
                end
            end
        join
        checks++; if (got !== STEPS) begin errors++; $display("FAIL run_transfers got=%0d want=%0d", got, STEPS); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL run_done_pulses got=%0d want=1", dones); end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL run_end busy=%0b ov=%0b left=%0d want 0/0/0", busy, out_valid, exp_q.size()); end
    endtask

    task automatic test_ignored_events();
        test_full_run(1'b1);
        checks++; if (h_vec !== fin_h || c_vec !== fin_c) begin errors++; $display("FAIL ignored_final got=%h want=%h", h_vec, fin_h); end
        checks++; if (step_idx !== SW'(STEPS)) begin errors++; $display("FAIL ignored_step_idx got=%0d want=%0d", step_idx, STEPS); end
    endtask

    task automatic test_reset_midrun();
        int dones;
        do_reset();
        out_ack = 1'b1;
        pulse_start();
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < N; k++) send(hval(s, k), cval(s, k), 1'b0);
        for (int k = 0; k < 7; k++) send(hval(2, k), cval(2, k), 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || h_vec !== '0 || c_vec !== '0) begin errors++; $display("FAIL midrst_outputs ov=%0b h=%h want 0", out_valid, h_vec); end
        checks++; if (step_idx !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ctrl idx=%0d busy=%0b rdy=%0b want 0", step_idx, busy, in_ready); end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b1;
        out_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_done got=%0d want=0", dones); end
        pulse_start();
        for (int k = 0; k < N; k++) send(hval(5, k), cval(5, k), 1'b0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || h_vec !== mk_h(5) || c_vec !== mk_c(5)) begin errors++; $display("FAIL midrst_restart ov=%0b h=%h want ov=1 h=%h", out_valid, h_vec, mk_h(5)); end
        checks++; if (step_idx !== SW'(1)) begin errors++; $display("FAIL midrst_step_idx got=%0d want=1", step_idx); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_backpressure();
        test_full_run(1'b0);
        fin_h = h_vec;
        fin_c = c_vec;
        test_ignored_events();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
